// File: rtl/svm_score_collect.sv
// rtl/svm_score_collect.sv - slice-sum accumulator, bias add and threshold for svmrow_mem bursts
module svm_score_collect #(
   parameter int SWIDTH  = 32,
   parameter int AWIDTH  = 40,
   parameter int BWIDTH  = 16,
   parameter int NSCORES = 64,
   parameter int NSLICES = 4,
   localparam int IW = (NSCORES > 1) ? $clog2(NSCORES) : 1,
   localparam int LW = (NSLICES > 1) ? $clog2(NSLICES) : 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic signed [SWIDTH-1:0] svm_data,
   input  logic                     dvo_in,
   input  logic signed [BWIDTH-1:0] bias,
   input  logic signed [AWIDTH-1:0] threshold,
   input  logic                     clear,
   output logic signed [AWIDTH-1:0] score_out,
   output logic                     score_valid,
   output logic [IW-1:0]            score_index,
   output logic                     detect,
   output logic                     frame_done,
   output logic                     burst_err,
   output logic                     sat_err
);

   // Two guard bits cover the worst case of three AWIDTH-range terms.
   localparam int WW = AWIDTH + 2;
   localparam logic signed [WW-1:0] MAX_W = {3'b000, {(AWIDTH-1){1'b1}}};
   localparam logic signed [WW-1:0] MIN_W = {3'b111, {(AWIDTH-1){1'b0}}};

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t                   state;
   logic [IW-1:0]            idx;
   logic [LW-1:0]            slice;
   logic signed [AWIDTH-1:0] p_mem [NSCORES];

   logic                     take;
   logic                     first_slice;
   logic                     last_slice;
   logic                     last_elem;
   logic signed [AWIDTH-1:0] p_rd;
   logic signed [WW-1:0]     p_ext;
   logic signed [WW-1:0]     d_ext;
   logic signed [WW-1:0]     b_ext;
   logic signed [WW-1:0]     sum_w;
   logic                     sum_hi;
   logic                     sum_lo;
   logic signed [AWIDTH-1:0] sum_c;

   // A clear on the same cycle as a valid sample drops that sample.
   assign take        = dvo_in & ~clear;
   assign first_slice = (slice == '0);
   assign last_slice  = (slice == LW'(NSLICES - 1));
   assign last_elem   = (idx == IW'(NSCORES - 1));
   assign p_rd        = p_mem[idx];

   // Element sum: slice 0 ignores stale P, only the last slice adds bias; clamp to AWIDTH.
   always_comb begin
      p_ext  = first_slice ? '0 : {{2{p_rd[AWIDTH-1]}}, p_rd};
      d_ext  = {{(WW-SWIDTH){svm_data[SWIDTH-1]}}, svm_data};
      b_ext  = last_slice ? {{(WW-BWIDTH){bias[BWIDTH-1]}}, bias} : '0;
      sum_w  = p_ext + d_ext + b_ext;
      sum_hi = (sum_w > MAX_W);
      sum_lo = (sum_w < MIN_W);
      if (sum_hi) begin
         sum_c = MAX_W[AWIDTH-1:0];
      end else if (sum_lo) begin
         sum_c = MIN_W[AWIDTH-1:0];
      end else begin
         sum_c = sum_w[AWIDTH-1:0];
      end
   end

   // Partial sums of the non-final slices; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (take && !last_slice) begin
         p_mem[idx] <= sum_c;
      end
   end

   // Burst sequencing, sticky error flags and the registered score outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         idx         <= '0;
         slice       <= '0;
         score_out   <= '0;
         score_valid <= 1'b0;
         score_index <= '0;
         detect      <= 1'b0;
         frame_done  <= 1'b0;
         burst_err   <= 1'b0;
         sat_err     <= 1'b0;
      end else begin
         score_valid <= 1'b0;
         detect      <= 1'b0;
         frame_done  <= 1'b0;
         if (clear) begin
            state     <= IDLE;
            idx       <= '0;
            slice     <= '0;
            burst_err <= 1'b0;
            sat_err   <= 1'b0;
         end else if (take) begin
            if (sum_hi || sum_lo) begin
               sat_err <= 1'b1;
            end
            if (last_slice) begin
               score_valid <= 1'b1;
               score_out   <= sum_c;
               score_index <= idx;
               detect      <= (sum_c > threshold);
               frame_done  <= last_elem;
            end
            // Returning to IDLE after the last element lets a back-to-back burst start on the next cycle.
            if (last_elem) begin
               state <= IDLE;
               idx   <= '0;
               slice <= last_slice ? '0 : slice + 1'b1;
            end else begin
               state <= BURST;
               idx   <= idx + 1'b1;
            end
         end else if (state == BURST) begin
            // A gap inside a burst abandons the whole frame.
            burst_err <= 1'b1;
            state     <= IDLE;
            idx       <= '0;
            slice     <= '0;
         end
      end
   end

endmodule

// File: tb/tb_svm_score_collect.sv
// tb/tb_svm_score_collect.sv - scoreboard bench for svm_score_collect
`timescale 1ns/1ps
module tb_svm_score_collect;

   localparam int SW  = 32;
   localparam int AW  = 40;
   localparam int BW  = 16;
   localparam int NS  = 64;
   localparam int NL  = 4;
   localparam int AW2 = 34;
   localparam int NS2 = 4;
   localparam longint MAXP2 = 64'sd8589934591;
   localparam longint MINN2 = -64'sd8589934592;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic signed [SW-1:0]  svm_data = '0;
   logic                  dvo_in = 1'b0;
   logic signed [BW-1:0]  bias = '0;
   logic signed [AW-1:0]  threshold = '0;
   logic                  clear = 1'b0;
   logic signed [AW-1:0]  score_out;
   logic                  score_valid;
   logic [5:0]            score_index;
   logic                  detect;
   logic                  frame_done;
   logic                  burst_err;
   logic                  sat_err;

   logic signed [SW-1:0]  svm2 = '0;
   logic                  dvo2 = 1'b0;
   logic signed [BW-1:0]  bias2 = '0;
   logic signed [AW2-1:0] thr2 = '0;
   logic                  clear2 = 1'b0;
   logic signed [AW2-1:0] score2;
   logic                  valid2;
   logic [1:0]            index2;
   logic                  detect2;
   logic                  fdone2;
   logic                  berr2;
   logic                  sat2;

   svm_score_collect #(.SWIDTH(SW), .AWIDTH(AW), .BWIDTH(BW), .NSCORES(NS), .NSLICES(NL)) dut (
      .clk(clk), .reset_n(reset_n), .svm_data(svm_data), .dvo_in(dvo_in), .bias(bias),
      .threshold(threshold), .clear(clear), .score_out(score_out), .score_valid(score_valid),
      .score_index(score_index), .detect(detect), .frame_done(frame_done),
      .burst_err(burst_err), .sat_err(sat_err)
   );

   svm_score_collect #(.SWIDTH(SW), .AWIDTH(AW2), .BWIDTH(BW), .NSCORES(NS2), .NSLICES(NL)) dut2 (
      .clk(clk), .reset_n(reset_n), .svm_data(svm2), .dvo_in(dvo2), .bias(bias2),
      .threshold(thr2), .clear(clear2), .score_out(score2), .score_valid(valid2),
      .score_index(index2), .detect(detect2), .frame_done(fdone2),
      .burst_err(berr2), .sat_err(sat2)
   );

   typedef struct {
      longint score;
      int     idx;
      bit     det;
      bit     fd;
      int     cyc;
   } exp_t;

   exp_t   q1[$];
   exp_t   q2[$];
   int     errors = 0;
   int     checks = 0;
   longint acc [NS];
   int     b_slice = 0;

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic longint clampw(input longint v, input int w);
      longint mx;
      longint mn;
      mx = (longint'(1) << (w - 1)) - 1;
      mn = -(longint'(1) << (w - 1));
      return (v > mx) ? mx : ((v < mn) ? mn : v);
   endfunction

   // Scoreboard monitors: every presented score must match the oldest expectation.
   always @(negedge clk) begin : mon1
      exp_t e;
      if (score_valid === 1'b1) begin
         if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_score: got index %0d, expected no output", score_index);
         end else begin
            e = q1.pop_front();
            chk("score_out", score_out, e.score);
            chk("score_index", score_index, e.idx);
            chk("detect", detect, e.det);
            chk("frame_done", frame_done, e.fd);
            chk("latency_cycle", cyc, e.cyc);
         end
      end else if (reset_n === 1'b1 && (detect !== 1'b0 || frame_done !== 1'b0)) begin
         checks++;
         errors++;
         $display("FAIL idle_strobe: got detect=%b frame_done=%b, expected 0", detect, frame_done);
      end
   end

   always @(negedge clk) begin : mon2
      exp_t e;
      if (valid2 === 1'b1) begin
         if (q2.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_score2: got index %0d, expected no output", index2);
         end else begin
            e = q2.pop_front();
            chk("sat_score_out", score2, e.score);
            chk("sat_score_index", index2, e.idx);
            chk("sat_detect", detect2, e.det);
            chk("sat_frame_done", fdone2, e.fd);
            chk("sat_latency_cycle", cyc, e.cyc);
         end
      end
   end

   // One element into the main DUT; the bench model decides what score, if any, it yields.
   task automatic elem(input int i, input longint v);
      longint s;
      @(negedge clk);
      dvo_in   = 1'b1;
      svm_data = SW'(v);
      if (b_slice == NL - 1) begin
         s = clampw(acc[i] + v + longint'(bias), AW);
         q1.push_back('{s, i, (s > longint'(threshold)), (i == NS - 1), cyc + 1});
      end else if (b_slice == 0) begin
         acc[i] = v;
      end else begin
         acc[i] = clampw(acc[i] + v, AW);
      end
   endtask

   // mode 0: ramp idx+1, mode 1: constant -5, otherwise random
   task automatic burst(input int mode);
      longint v;
      for (int i = 0; i < NS; i++) begin
         case (mode)
            0:       v = i + 1;
            1:       v = -5;
            default: v = longint'($urandom_range(0, 1 << 20)) - (1 << 19);
         endcase
         elem(i, v);
      end
      b_slice = (b_slice + 1) % NL;
   endtask

   task automatic idle();
      @(negedge clk);
      dvo_in = 1'b0;
   endtask

   task automatic frame2(input longint v, input longint exp_s, input bit exp_d);
      for (int s = 0; s < NL; s++) begin
         for (int i = 0; i < NS2; i++) begin
            @(negedge clk);
            dvo2 = 1'b1;
            svm2 = SW'(v);
            if (s == NL - 1) q2.push_back('{exp_s, i, exp_d, (i == NS2 - 1), cyc + 1});
         end
      end
      @(negedge clk);
      dvo2 = 1'b0;
      @(negedge clk);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      #2;
      chk("rst_score_valid", score_valid, 0);
      chk("rst_score_out", score_out, 0);
      chk("rst_score_index", score_index, 0);
      chk("rst_detect", detect, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_burst_err", burst_err, 0);
      chk("rst_sat_err", sat_err, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Ramp frame
      repeat (4) burst(0);
      idle();

      // Bias and threshold, strict compare at equality then just below
      bias = 16'sd25;
      threshold = 40'sd5;
      repeat (4) burst(1);
      idle();
      threshold = 40'sd4;
      repeat (4) burst(1);
      idle();

      // Truncated slice 1, then a full frame over stale partial sums
      bias = '0;
      threshold = '0;
      burst(0);
      for (int i = 0; i < 10; i++) elem(i, 7);
      idle();
      b_slice = 0;
      @(negedge clk);
      chk("burst_err_set", burst_err, 1);
      repeat (4) burst(0);
      idle();
      chk("burst_err_sticky", burst_err, 1);

      // Clear on element 5 of slice 2, then two back-to-back frames
      bias = 16'sd300;
      burst(2);
      burst(2);
      for (int i = 0; i < 5; i++) elem(i, 1000 + i);
      @(negedge clk);
      dvo_in = 1'b1;
      svm_data = 32'sd12345;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      dvo_in = 1'b0;
      b_slice = 0;
      @(negedge clk);
      chk("clear_burst_err", burst_err, 0);
      chk("clear_sat_err", sat_err, 0);
      chk("clear_score_valid", score_valid, 0);
      repeat (8) burst(2);
      idle();

      // Reset in the middle of slice 3
      repeat (3) burst(2);
      for (int i = 0; i < 20; i++) elem(i, 50 * i - 400);
      @(negedge clk);
      dvo_in = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_score_valid", score_valid, 0);
      chk("mid_rst_score_out", score_out, 0);
      chk("mid_rst_score_index", score_index, 0);
      chk("mid_rst_detect", detect, 0);
      chk("mid_rst_frame_done", frame_done, 0);
      b_slice = 0;
      bias = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) burst(0);
      idle();

      // Saturation on the narrow-accumulator instance
      bias2 = 16'sd100;
      thr2 = '0;
      frame2(64'sd2147483647, MAXP2, 1'b1);
      chk("sat_err_pos", sat2, 1);
      clear2 = 1'b1;
      @(negedge clk);
      clear2 = 1'b0;
      chk("sat_err_cleared", sat2, 0);
      bias2 = -16'sd100;
      frame2(-64'sd2147483648, MINN2, 1'b0);
      chk("sat_err_neg", sat2, 1);
      chk("sat_burst_err", berr2, 0);

      for (int k = 0; k < 10 && (q1.size() + q2.size()) != 0; k++) @(negedge clk);
      chk("queue_drained", q1.size() + q2.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
